// File: rtl/div_share_pkg.sv
// Shared types and constants for the shared-divider arbiter.
// Optional feature macro: DIV_SHARE_DZ_FAST_EN (used by div_share_arb).
package div_share_pkg;

  localparam int DEF_NREQ  = 4;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_IDW   = $clog2(DEF_NREQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Response record at the default geometry.
  typedef struct packed {
    logic [DEF_IDW-1:0]   id;
    logic [DEF_WIDTH-1:0] quotient;
    logic [DEF_WIDTH-1:0] remainder;
    logic                 dz;
  } rsp_t;

endpackage

// File: rtl/div_share_arb_if.sv
// Request/response bundle between the requesters and the shared divider.
// master = requester/consumer side, slave = div_share_arb.
interface div_share_arb_if
  import div_share_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int WIDTH = DEF_WIDTH,
  parameter int IDW   = $clog2(NREQ)
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_dividend;
  logic [NREQ*WIDTH-1:0] req_divisor;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_quotient;
  logic [WIDTH-1:0]      rsp_remainder;
  logic                  rsp_dz;

  modport master (
    output req_valid, req_dividend, req_divisor, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_dz
  );

  modport slave (
    input  req_valid, req_dividend, req_divisor, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_dz
  );
endinterface

// File: rtl/div_share_arb_step_core.sv
// Iterative unsigned restoring divider: one quotient bit per cycle after start.
// done is high during the final step; quotient/remainder show that step's result.
module div_step_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);
  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] divisor_reg;
  logic [WIDTH-1:0] quo_reg;
  logic [WIDTH:0]   rem_reg;
  logic [CW-1:0]    count_reg;
  logic             busy_reg;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   rem_next;
  logic [WIDTH-1:0] quo_next;
  logic             fits;
  logic             unused_rem_msb;

  // The extra remainder bit keeps the compare exact once the shifted value exceeds WIDTH bits.
  always_comb begin
    shifted  = {rem_reg[WIDTH-1:0], quo_reg[WIDTH-1]};
    fits     = (shifted >= {1'b0, divisor_reg});
    rem_next = fits ? (shifted - {1'b0, divisor_reg}) : shifted;
    quo_next = {quo_reg[WIDTH-2:0], fits};
  end

  assign done           = busy_reg && (count_reg == CW'(WIDTH - 1));
  assign quotient       = quo_next;
  assign remainder      = rem_next[WIDTH-1:0];
  assign unused_rem_msb = rem_reg[WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      divisor_reg <= '0;
      quo_reg     <= '0;
      rem_reg     <= '0;
      count_reg   <= '0;
      busy_reg    <= 1'b0;
    end else if (start) begin
      divisor_reg <= divisor;
      quo_reg     <= dividend;
      rem_reg     <= '0;
      count_reg   <= '0;
      busy_reg    <= 1'b1;
    end else if (busy_reg) begin
      quo_reg   <= quo_next;
      rem_reg   <= rem_next;
      count_reg <= count_reg + 1'b1;
      if (done) busy_reg <= 1'b0;
    end
  end
endmodule

// File: rtl/div_share_arb.sv
// Round-robin arbiter sharing one restoring divider among NREQ requesters.
// Define DIV_SHARE_DZ_FAST_EN to answer zero-divisor requests without iterating.
module div_share_arb
  import div_share_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int WIDTH = DEF_WIDTH,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  div_share_arb_if.slave   bus
);
  state_t           state_reg, state_next;
  logic [IDW-1:0]   rr_ptr_reg, id_reg, gnt_idx;
  logic             gnt_any, accept, core_start, core_done, sel_dz;
  logic [WIDTH-1:0] dividend_arr [NREQ];
  logic [WIDTH-1:0] divisor_arr  [NREQ];
  logic [WIDTH-1:0] sel_dividend, sel_divisor, core_quo, core_rem;
  logic [IDW-1:0]   rsp_id_reg;
  logic [WIDTH-1:0] rsp_quo_reg, rsp_rem_reg;
  int               slot;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_req
      assign dividend_arr[gi]  = bus.req_dividend[gi*WIDTH +: WIDTH];
      assign divisor_arr[gi]   = bus.req_divisor[gi*WIDTH +: WIDTH];
      assign bus.req_ready[gi] = accept && (gnt_idx == IDW'(gi));
    end
  endgenerate

  // First valid requester at or after rr_ptr, wrapping around.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    slot    = 0;
    for (int k = 0; k < NREQ; k++) begin
      slot = int'(rr_ptr_reg) + k;
      if (slot >= NREQ) slot = slot - NREQ;
      if (!gnt_any && bus.req_valid[slot]) begin
        gnt_any = 1'b1;
        gnt_idx = IDW'(slot);
      end
    end
  end

  assign sel_dividend = dividend_arr[gnt_idx];
  assign sel_divisor  = divisor_arr[gnt_idx];
`ifdef DIV_SHARE_DZ_FAST_EN
  assign sel_dz = (sel_divisor == '0);
`else
  assign sel_dz = 1'b0;
`endif

  div_step_core #(.WIDTH(WIDTH)) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (core_start),
    .dividend  (sel_dividend),
    .divisor   (sel_divisor),
    .done      (core_done),
    .quotient  (core_quo),
    .remainder (core_rem)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (gnt_any) state_next = sel_dz ? DONE : BUSY;
      BUSY:    if (core_done) state_next = DONE;
      DONE:    if (bus.rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    accept        = (state_reg == IDLE) && gnt_any;
    core_start    = accept && !sel_dz;
    bus.rsp_valid = (state_reg == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_reg  <= '0;
      id_reg      <= '0;
      rsp_id_reg  <= '0;
      rsp_quo_reg <= '0;
      rsp_rem_reg <= '0;
    end else begin
      if (accept) id_reg <= gnt_idx;
`ifdef DIV_SHARE_DZ_FAST_EN
      if (accept && sel_dz) begin
        rsp_id_reg  <= gnt_idx;
        rsp_quo_reg <= '1;
        rsp_rem_reg <= sel_dividend;
      end
`endif
      if ((state_reg == BUSY) && core_done) begin
        rsp_id_reg  <= id_reg;
        rsp_quo_reg <= core_quo;
        rsp_rem_reg <= core_rem;
      end
      if ((state_reg == DONE) && bus.rsp_ready)
        rr_ptr_reg <= (id_reg == IDW'(NREQ - 1)) ? '0 : id_reg + 1'b1;
    end
  end

`ifdef DIV_SHARE_DZ_FAST_EN
  logic rsp_dz_reg;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             rsp_dz_reg <= 1'b0;
    else if (accept)                        rsp_dz_reg <= sel_dz;
  end
  assign bus.rsp_dz = rsp_dz_reg;
`else
  assign bus.rsp_dz = 1'b0;
`endif

  assign bus.rsp_id        = rsp_id_reg;
  assign bus.rsp_quotient  = rsp_quo_reg;
  assign bus.rsp_remainder = rsp_rem_reg;
endmodule

// File: tb/tb_div_share_arb.sv
// Directed self-checking bench for div_share_arb (default NREQ=4, WIDTH=32).
`timescale 1ns/1ps
module tb_div_share_arb;
  import div_share_pkg::*;

  localparam int NREQ  = DEF_NREQ;
  localparam int WIDTH = DEF_WIDTH;
  localparam int LAT   = WIDTH + 1;
`ifdef DIV_SHARE_DZ_FAST_EN
  localparam bit DZ_FAST = 1'b1;
`else
  localparam bit DZ_FAST = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  div_share_arb_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();
  div_share_arb #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic rsp_t observed();
    rsp_t r;
    r.id        = bus.rsp_id;
    r.quotient  = bus.rsp_quotient;
    r.remainder = bus.rsp_remainder;
    r.dz        = bus.rsp_dz;
    return r;
  endfunction

  task automatic set_req(input int i, input logic [WIDTH-1:0] dvd, input logic [WIDTH-1:0] dvs);
    bus.req_dividend[i*WIDTH +: WIDTH] = dvd;
    bus.req_divisor[i*WIDTH +: WIDTH]  = dvs;
  endtask

  // Called at a negedge; returns in the grant cycle (negedge + 1).
  task automatic wait_grant(output int idx, output int t, output bit ok);
    ok = 1'b0; idx = -1; t = 0;
    for (int n = 0; n < 200; n++) begin
      #1;
      if (bus.req_ready != '0) begin
        for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) idx = i;
        t = cyc; ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_rsp(output int t, output bit ok);
    ok = 1'b0; t = 0;
    for (int n = 0; n < 200; n++) begin
      if (bus.rsp_valid) begin t = cyc; ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Full single operation with rsp_ready high; returns observations only.
  task automatic run_op(input int i, input logic [WIDTH-1:0] dvd, input logic [WIDTH-1:0] dvs,
                        output int idx, output rsp_t got, output int lat, output bit ok);
    int ta, tr;
    bit ok1, ok2;
    set_req(i, dvd, dvs);
    bus.req_valid[i] = 1'b1;
    wait_grant(idx, ta, ok1);
    next_cycle();
    bus.req_valid[i] = 1'b0;
    wait_rsp(tr, ok2);
    got = observed();
    lat = tr - ta;
    ok  = ok1 && ok2;
    $display("op req=%0d %0d/%0d -> id=%0d q=%0h r=%0h dz=%0b lat=%0d", i, dvd, dvs,
             got.id, got.quotient, got.remainder, got.dz, lat);
    next_cycle();
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req_valid = '0; bus.rsp_ready = 1'b1;
    bus.req_dividend = '0; bus.req_divisor = '0;
    repeat (3) @(negedge clk);
    total++;
    if (observed() !== rsp_t'(0) || bus.rsp_valid !== 1'b0) begin
      bad++; $display("FAIL reset_outputs: got v=%b %h want v=0 all zero", bus.rsp_valid, observed());
    end
    total++;
    if (bus.req_ready !== '0) begin
      bad++; $display("FAIL reset_ready: got %b want 0", bus.req_ready);
    end
    rst_n = 1'b1;
    next_cycle();
    total++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== '0) begin
      bad++; $display("FAIL idle_after_reset: got v=%b rdy=%b want 0/0", bus.rsp_valid, bus.req_ready);
    end
    $display("reset checked");
  endtask

  task automatic test_single();
    int idx, lat; rsp_t got; bit ok;
    rsp_t exp = '{id: 2'd2, quotient: 32'd14, remainder: 32'd2, dz: 1'b0};
    run_op(2, 32'd100, 32'd7, idx, got, lat, ok);
    total++; if (!ok) begin bad++; $display("FAIL single_timeout: got no handshake want one"); end
    total++; if (idx !== 2) begin bad++; $display("FAIL single_grant: got %0d want 2", idx); end
    total++; if (lat !== LAT) begin bad++; $display("FAIL single_latency: got %0d want %0d", lat, LAT); end
    total++; if (got !== exp) begin bad++; $display("FAIL single_result: got %h want %h", got, exp); end
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL single_drop: got v=%b want 0", bus.rsp_valid); end
  endtask

  task automatic test_round_robin();
    int order [6] = '{0, 1, 2, 3, 0, 1};
    logic [WIDTH-1:0] q_tab [4] = '{32'd333, 32'd277, 32'd244, 32'd222};
    logic [WIDTH-1:0] r_tab [4] = '{32'd1, 32'd3, 32'd2, 32'd1};
    int idx, ta, prev_ta, tr; bit ok; rsp_t exp, got;
    pulse_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, WIDTH'(1000 + 111*i), WIDTH'(3 + i));
    bus.req_valid = '1;
    prev_ta = 0;
    for (int n = 0; n < 6; n++) begin
      wait_grant(idx, ta, ok);
      total++; if (!ok || idx !== order[n]) begin
        bad++; $display("FAIL rr_grant%0d: got %0d want %0d", n, idx, order[n]);
      end
      if (n > 0) begin
        total++; if (ta - prev_ta !== WIDTH + 2) begin
          bad++; $display("FAIL rr_throughput%0d: got %0d want %0d", n, ta - prev_ta, WIDTH + 2);
        end
      end
      prev_ta = ta;
      next_cycle();
      if (n == 5) bus.req_valid = '0;
      wait_rsp(tr, ok);
      exp = '{id: 2'(order[n]), quotient: q_tab[order[n]], remainder: r_tab[order[n]], dz: 1'b0};
      got = observed();
      $display("rr op %0d id=%0d q=%0d r=%0d", n, got.id, got.quotient, got.remainder);
      total++; if (!ok || got !== exp) begin
        bad++; $display("FAIL rr_result%0d: got %h want %h", n, got, exp);
      end
      next_cycle();
    end
  endtask

  task automatic test_boundary();
    int rq [2] = '{1, 3};
    logic [WIDTH-1:0] dvd [2] = '{32'hFFFF_FFFF, 32'd5};
    logic [WIDTH-1:0] dvs [2] = '{32'd1, 32'd9};
    logic [WIDTH-1:0] eq  [2] = '{32'hFFFF_FFFF, 32'd0};
    logic [WIDTH-1:0] er  [2] = '{32'd0, 32'd5};
    int idx, lat; rsp_t got, exp; bit ok;
    for (int k = 0; k < 2; k++) begin
      run_op(rq[k], dvd[k], dvs[k], idx, got, lat, ok);
      exp = '{id: 2'(rq[k]), quotient: eq[k], remainder: er[k], dz: 1'b0};
      total++; if (!ok || got !== exp) begin
        bad++; $display("FAIL boundary%0d: got %h want %h", k, got, exp);
      end
    end
  endtask

  task automatic test_backpressure();
    int idx, ta, tr; bit ok, stable;
    rsp_t exp0 = '{id: 2'd0, quotient: 32'd22, remainder: 32'd2, dz: 1'b0};
    rsp_t exp1 = '{id: 2'd1, quotient: 32'd11, remainder: 32'd0, dz: 1'b0};
    bus.rsp_ready = 1'b0;
    set_req(0, 32'd200, 32'd9);
    bus.req_valid[0] = 1'b1;
    wait_grant(idx, ta, ok);
    total++; if (!ok || idx !== 0) begin bad++; $display("FAIL bp_grant0: got %0d want 0", idx); end
    next_cycle();
    bus.req_valid[0] = 1'b0;
    set_req(1, 32'd77, 32'd7);
    bus.req_valid[1] = 1'b1;
    wait_rsp(tr, ok);
    total++; if (!ok) begin bad++; $display("FAIL bp_rsp_timeout: got no rsp_valid want one"); end
    for (int k = 0; k < 10; k++) begin
      #1;
      stable = (bus.rsp_valid === 1'b1) && (observed() === exp0) && (bus.req_ready === '0);
      total++; if (!stable) begin
        bad++; $display("FAIL bp_hold%0d: got v=%b %h rdy=%b want v=1 %h rdy=0", k,
                        bus.rsp_valid, observed(), bus.req_ready, exp0);
      end
      @(negedge clk);
    end
    $display("bp held id=%0d q=%0d r=%0d", bus.rsp_id, bus.rsp_quotient, bus.rsp_remainder);
    bus.rsp_ready = 1'b1;
    next_cycle();
    #1;
    total++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 4'b0010) begin
      bad++; $display("FAIL bp_resume: got v=%b rdy=%b want v=0 rdy=0010", bus.rsp_valid, bus.req_ready);
    end
    next_cycle();
    bus.req_valid[1] = 1'b0;
    wait_rsp(tr, ok);
    total++; if (!ok || observed() !== exp1) begin
      bad++; $display("FAIL bp_second: got %h want %h", observed(), exp1);
    end
    $display("bp second id=%0d q=%0d r=%0d", bus.rsp_id, bus.rsp_quotient, bus.rsp_remainder);
    next_cycle();
  endtask

  task automatic test_div_zero();
    int idx, lat; rsp_t got; bit ok;
    rsp_t exp = '{id: 2'd2, quotient: 32'hFFFF_FFFF, remainder: 32'd55, dz: DZ_FAST};
    run_op(2, 32'd55, 32'd0, idx, got, lat, ok);
    total++; if (!ok || got !== exp) begin bad++; $display("FAIL dz_result: got %h want %h", got, exp); end
    total++; if (lat !== (DZ_FAST ? 1 : LAT)) begin
      bad++; $display("FAIL dz_latency: got %0d want %0d", lat, DZ_FAST ? 1 : LAT);
    end
  endtask

  task automatic test_reset_mid_busy();
    int idx, ta, tr; bit ok, seen;
    rsp_t exp = '{id: 2'd0, quotient: 32'd14, remainder: 32'd2, dz: 1'b0};
    set_req(3, 32'd100, 32'd7);
    bus.req_valid[3] = 1'b1;
    wait_grant(idx, ta, ok);
    total++; if (!ok || idx !== 3) begin bad++; $display("FAIL mid_grant: got %0d want 3", idx); end
    next_cycle();
    bus.req_valid[3] = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (bus.rsp_valid !== 1'b0) seen = 1'b1;
      @(negedge clk);
    end
    total++; if (seen) begin bad++; $display("FAIL mid_no_rsp: got rsp_valid=1 want 0"); end
    set_req(0, 32'd100, 32'd7);
    set_req(3, 32'd45, 32'd6);
    bus.req_valid = 4'b1001;
    wait_grant(idx, ta, ok);
    total++; if (!ok || idx !== 0) begin bad++; $display("FAIL mid_rr_ptr: got %0d want 0", idx); end
    next_cycle();
    bus.req_valid = '0;
    wait_rsp(tr, ok);
    total++; if (!ok || observed() !== exp) begin
      bad++; $display("FAIL mid_after: got %h want %h", observed(), exp);
    end
    $display("after reset id=%0d q=%0d r=%0d", bus.rsp_id, bus.rsp_quotient, bus.rsp_remainder);
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_boundary();
    test_backpressure();
    test_div_zero();
    test_reset_mid_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
